// File: rtl/cell_pos_streamer_pkg.sv
// Shared definitions for the cell position streamer.
//   - Default widths and depths used by the top module parameters.
//   - Field offsets of the {posz, posy, posx} position word.
//   - Width of the particle-count field held at memory address 0.
//   - FSM state encoding.
package cell_pos_streamer_pkg;

  localparam int CPS_DATA_WIDTH   = 96;
  localparam int CPS_ADDR_WIDTH   = 8;
  localparam int CPS_PARTICLE_NUM = 220;
  localparam int CPS_FIFO_DEPTH   = 4;

  // Position word layout: {posz, posy, posx}, one 32-bit field each.
  localparam int POS_FIELD_WIDTH = 32;
  localparam int POS_X_LSB       = 0;
  localparam int POS_Y_LSB       = 32;
  localparam int POS_Z_LSB       = 64;

  // The particle count sits in the low address-width bits of word 0.
  localparam int COUNT_WIDTH = CPS_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CNT_RD   = 3'd1,
    CNT_WAIT = 3'd2,
    STREAM   = 3'd3,
    FINISH   = 3'd4
  } state_t;

endpackage

// File: rtl/cell_pos_streamer_fifo.sv
// pos_stream_fifo: small synchronous FIFO with parameterised width and depth.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset; clears pointers, count and storage
//   push       write push_data at the tail (caller never pushes when full)
//   push_data  data to write
//   pop        remove the head entry (ignored when empty)
//   head_data  head entry; when empty it shows the most recently popped entry
//   empty      no entries held
//   count      number of entries held, 0..DEPTH
module pos_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] entry_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [DEPTH-1:0] wr_sel;
  logic [PW-1:0]    head_ptr;
  logic             do_pop;

  assign empty  = (count_reg == '0);
  assign count  = count_reg;
  assign do_pop = pop && !empty;

  // One-hot write select per storage entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    assign wr_sel[gi] = push && (wr_ptr_reg == PW'(gi));
  end

  // When empty, the slot behind the read pointer still holds the last popped
  // word and cannot be overwritten until the FIFO refills, so presenting it
  // keeps the output stable while no data is valid.
  assign head_ptr  = empty ? (rd_ptr_reg - PW'(1)) : rd_ptr_reg;
  assign head_data = entry_reg[head_ptr];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst) begin
        entry_reg[i] <= '0;
      end else if (wr_sel[i]) begin
        entry_reg[i] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/cell_pos_streamer.sv
// cell_pos_streamer: read sequencer in front of a per-cell position memory.
// Reads the particle count at address 0, then reads addresses 1..count and
// presents each position as a valid/ready stream. A credit-limited FIFO
// absorbs the 2-cycle memory read latency so backpressure never drops data.
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   start           one-cycle stream request, honoured only in IDLE
//   busy, done      busy while streaming; done pulses once at the end
//   mem_address     memory address (holds its last value between reads)
//   mem_rden        memory read enable
//   mem_wren        memory write enable, always 0
//   mem_q           memory read data, valid 2 cycles after mem_rden
//   out_valid/out_ready  output handshake
//   out_pos, out_index   position word and its memory address (1..count)
//   count_clamped   sticky: the count read exceeded PARTICLE_NUM-1
module cell_pos_streamer
  import cell_pos_streamer_pkg::*;
#(
  parameter int DATA_WIDTH   = CPS_DATA_WIDTH,
  parameter int PARTICLE_NUM = CPS_PARTICLE_NUM,
  parameter int ADDR_WIDTH   = CPS_ADDR_WIDTH,
  parameter int FIFO_DEPTH   = CPS_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  count_clamped
);

  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  // One extra bit so next_addr can step past the largest legal count.
  localparam int NW         = ADDR_WIDTH + 1;
  localparam int RET_STAGES = 2;
  localparam logic [NW-1:0] MAX_CNT = NW'(PARTICLE_NUM - 1);

  state_t                state_reg, state_next;
  logic                  wait_reg;
  logic [NW-1:0]         cnt_reg;
  logic [NW-1:0]         next_addr_reg;
  logic [1:0]            inflight_reg;
  logic [ADDR_WIDTH-1:0] addr_hold_reg;
  logic                  clamp_reg;

  // Read-return pipe: tracks each issued read until its data reaches mem_q.
  logic [RET_STAGES-1:0] ret_valid_reg, ret_valid_next;
  logic [ADDR_WIDTH-1:0] ret_addr_reg  [RET_STAGES];
  logic [ADDR_WIDTH-1:0] ret_addr_next [RET_STAGES];

  logic [NW-1:0]         cnt_raw, cnt_eff;
  logic                  cnt_over;
  logic                  issue, push, pop, credit_ok, drain_done;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] head_data;

  assign cnt_raw  = {1'b0, mem_q[ADDR_WIDTH-1:0]};
  assign cnt_over = (cnt_raw > MAX_CNT);
  assign cnt_eff  = cnt_over ? MAX_CNT : cnt_raw;

  // Reads in flight plus words already buffered may never exceed the FIFO
  // depth, which is what makes the unconditional push safe.
  assign credit_ok = (int'(inflight_reg) + int'(fifo_count)) < FIFO_DEPTH;
  assign issue     = (state_reg == STREAM) && (next_addr_reg <= cnt_reg) && credit_ok;

  assign push      = ret_valid_reg[RET_STAGES-1];
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // All data drained once nothing is in flight and the FIFO empties this cycle.
  assign drain_done = (inflight_reg == 2'd0) &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  for (genvar gi = 0; gi < RET_STAGES; gi++) begin : g_ret_pipe
    if (gi == 0) begin : g_head
      assign ret_valid_next[gi] = issue;
      assign ret_addr_next[gi]  = next_addr_reg[ADDR_WIDTH-1:0];
    end else begin : g_tail
      assign ret_valid_next[gi] = ret_valid_reg[gi-1];
      assign ret_addr_next[gi]  = ret_addr_reg[gi-1];
    end
  end

  assign mem_rden    = issue || (state_reg == CNT_RD);
  assign mem_address = (state_reg == CNT_RD) ? '0 :
                       issue                 ? next_addr_reg[ADDR_WIDTH-1:0] :
                                               addr_hold_reg;
  assign mem_wren      = 1'b0;
  assign busy          = (state_reg == CNT_RD) || (state_reg == CNT_WAIT) || (state_reg == STREAM);
  assign done          = (state_reg == FINISH);
  assign count_clamped = clamp_reg;
  assign out_pos       = head_data[ADDR_WIDTH +: DATA_WIDTH];
  assign out_index     = head_data[ADDR_WIDTH-1:0];

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:     if (start) state_next = CNT_RD;
      CNT_RD:   state_next = CNT_WAIT;
      CNT_WAIT: if (wait_reg) state_next = (cnt_eff == '0) ? FINISH : STREAM;
      STREAM:   if ((next_addr_reg > cnt_reg) && drain_done) state_next = FINISH;
      FINISH:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      wait_reg      <= 1'b0;
      cnt_reg       <= '0;
      next_addr_reg <= '0;
      inflight_reg  <= 2'd0;
      addr_hold_reg <= '0;
      clamp_reg     <= 1'b0;
      ret_valid_reg <= '0;
      for (int i = 0; i < RET_STAGES; i++) begin
        ret_addr_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      // Second CNT_WAIT cycle is the one where the count word is on mem_q.
      wait_reg  <= (state_reg == CNT_WAIT) && !wait_reg;

      if ((state_reg == IDLE) && start) begin
        clamp_reg <= 1'b0;
      end

      if ((state_reg == CNT_WAIT) && wait_reg) begin
        cnt_reg       <= cnt_eff;
        next_addr_reg <= NW'(1);
        if (cnt_over) begin
          clamp_reg <= 1'b1;
        end
      end else if (issue) begin
        next_addr_reg <= next_addr_reg + NW'(1);
      end

      if (mem_rden) begin
        addr_hold_reg <= mem_address;
      end

      case ({issue, push})
        2'b10:   inflight_reg <= inflight_reg + 2'd1;
        2'b01:   inflight_reg <= inflight_reg - 2'd1;
        default: inflight_reg <= inflight_reg;
      endcase

      ret_valid_reg <= ret_valid_next;
      ret_addr_reg  <= ret_addr_next;
    end
  end

  pos_stream_fifo #(
    .WIDTH (DATA_WIDTH + ADDR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({mem_q, ret_addr_reg[RET_STAGES-1]}),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_cell_pos_streamer.sv
module tb_cell_pos_streamer;
  import cell_pos_streamer_pkg::*;

  localparam int DW   = CPS_DATA_WIDTH;
  localparam int AW   = CPS_ADDR_WIDTH;
  localparam int PN   = CPS_PARTICLE_NUM;
  localparam int FD   = CPS_FIFO_DEPTH;
  localparam int MAXC = PN - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, mem_rden, mem_wren, out_valid, count_clamped;
  logic [AW-1:0] mem_address, out_index;
  logic [DW-1:0] mem_q, out_pos;

  always #5 clk = ~clk;

  cell_pos_streamer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .mem_address   (mem_address),
    .mem_rden      (mem_rden),
    .mem_wren      (mem_wren),
    .mem_q         (mem_q),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pos       (out_pos),
    .out_index     (out_index),
    .count_clamped (count_clamped)
  );

  // Behavioural memory: data appears 2 cycles after the read-enable cycle;
  // filler appears when not reading so a mistimed capture shows up.
  logic [DW-1:0] mem_model [256];
  logic [DW-1:0] q_p1;
  always @(posedge clk) begin
    q_p1  <= mem_rden ? mem_model[mem_address] : {3{32'hdeadbeef}};
    mem_q <= q_p1;
  end

  typedef struct packed {
    logic [DW-1:0] pos;
    logic [AW-1:0] idx;
  } beat_t;

  typedef struct {
    int count_field;
    int mode;        // 0 ready=1, 1 toggle, 2 ready=0 for 10 cycles, 3 random
    int exp_beats;
    int exp_clamp;
  } vec_t;

  beat_t exp_q[$];
  beat_t last_exp;
  vec_t  vecs[8];

  int checks = 0;
  int errors = 0;

  int beats, issued, max_outst, first_issue, first_valid, cnt_rd_cyc;
  int last_pop, done_cyc, busy_err, bubbles, wren_err, addr_err;
  bit done_seen;

  task automatic check(input string name, input bit ok,
                       input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, out_valid == 1'b0, out_valid, 0);
    check({tag, "_out_pos"}, out_pos == '0, out_pos, 0);
    check({tag, "_out_index"}, out_index == '0, out_index, 0);
    check({tag, "_busy"}, busy == 1'b0, busy, 0);
    check({tag, "_done"}, done == 1'b0, done, 0);
    check({tag, "_mem_rden"}, mem_rden == 1'b0, mem_rden, 0);
    check({tag, "_mem_address"}, mem_address == '0, mem_address, 0);
    check({tag, "_mem_wren"}, mem_wren == 1'b0, mem_wren, 0);
    check({tag, "_count_clamped"}, count_clamped == 1'b0, count_clamped, 0);
  endtask

  // Fill the memory and build the expected stream: addresses 1..min(count, PN-1).
  task automatic load_cell(input int count_field);
    logic [DW-1:0] w;
    int n;
    w = {$urandom(), $urandom(), $urandom()};
    w[AW-1:0] = AW'(count_field);
    mem_model[0] = w;
    for (int a = 1; a < 256; a++) begin
      w[POS_X_LSB +: POS_FIELD_WIDTH] = $urandom();
      w[POS_Y_LSB +: POS_FIELD_WIDTH] = $urandom();
      w[POS_Z_LSB +: POS_FIELD_WIDTH] = $urandom();
      mem_model[a] = w;
    end
    n = (count_field > MAXC) ? MAXC : count_field;
    exp_q.delete();
    for (int a = 1; a <= n; a++) begin
      exp_q.push_back('{pos: mem_model[a], idx: AW'(a)});
    end
    last_exp = (n > 0) ? exp_q[n-1] : '0;
  endtask

  // Cycle 0 is the first cycle after the accepted start (CNT_RD).
  task automatic collect(input int mode, input int abort_beats);
    bit    stop;
    beat_t e;
    beats = 0; issued = 0; max_outst = 0; first_issue = -1; first_valid = -1;
    cnt_rd_cyc = -1; last_pop = -1; done_cyc = -1; done_seen = 0;
    busy_err = 0; bubbles = 0; wren_err = 0; addr_err = 0;
    stop = 0;
    for (int cyc = 0; cyc < 2000 && !stop; cyc++) begin
      @(negedge clk);
      start = (mode == 3 && cyc > 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2) == 0;
        2:       out_ready = (cyc >= 10);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (mem_wren) wren_err++;
      if (busy == done) busy_err++;
      if (mem_rden) begin
        if (mem_address == '0) begin
          if (cnt_rd_cyc < 0) cnt_rd_cyc = cyc;
          else addr_err++;
        end else begin
          if (int'(mem_address) != issued + 1) addr_err++;
          issued++;
          if (first_issue < 0) first_issue = cyc;
          if (issued - beats > max_outst) max_outst = issued - beats;
        end
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_ready && !out_valid && beats > 0 && exp_q.size() > 0) bubbles++;
      if (out_valid && out_ready) begin
        $display("beat cyc=%0d idx=%0d pos=%h", cyc, out_index, out_pos);
        if (exp_q.size() == 0) begin
          check("extra_beat", 1'b0, out_index, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_index", out_index == e.idx, out_index, e.idx);
          check("beat_pos", out_pos == e.pos, out_pos, e.pos);
        end
        beats++;
        last_pop = cyc;
        if (abort_beats > 0 && beats == abort_beats) stop = 1;
      end
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        stop      = 1;
      end
    end
  endtask

  task automatic run_stream(input string tag, input int count_field, input int mode,
                            input int exp_beats, input int exp_clamp, input int abort_beats);
    load_cell(count_field);
    @(negedge clk);
    start     = 1'b1;
    out_ready = 1'b0;
    collect(mode, abort_beats);
    if (abort_beats == 0) begin
      check({tag, "_done_seen"}, done_seen, done_seen, 1);
      check({tag, "_beats"}, beats == exp_beats, beats, exp_beats);
      check({tag, "_reads_issued"}, issued == exp_beats, issued, exp_beats);
      check({tag, "_max_outstanding"}, max_outst <= FD, max_outst, FD);
      check({tag, "_addr_seq"}, addr_err == 0, addr_err, 0);
      check({tag, "_wren"}, wren_err == 0, wren_err, 0);
      check({tag, "_busy"}, busy_err == 0, busy_err, 0);
      if (exp_beats > 0)
        check({tag, "_done_after_pop"}, done_cyc - last_pop == 1, done_cyc - last_pop, 1);
      else
        check({tag, "_done_after_cnt_rd"}, done_cyc - cnt_rd_cyc == 3, done_cyc - cnt_rd_cyc, 3);
      if (mode == 0 && exp_beats > 0)
        check({tag, "_first_latency"}, first_valid - first_issue == 3, first_valid - first_issue, 3);
      if (mode <= 1)
        check({tag, "_bubbles"}, bubbles == 0, bubbles, 0);
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b0;
      check({tag, "_busy_after"}, busy == 1'b0, busy, 0);
      check({tag, "_done_single"}, done == 1'b0, done, 0);
      check({tag, "_valid_after"}, out_valid == 1'b0, out_valid, 0);
      check({tag, "_clamped"}, count_clamped == exp_clamp[0], count_clamped, exp_clamp);
      if (exp_beats > 0) begin
        check({tag, "_hold_index"}, out_index == last_exp.idx, out_index, last_exp.idx);
        check({tag, "_hold_pos"}, out_pos == last_exp.pos, out_pos, last_exp.pos);
      end
      $display("stream %s count=%0d mode=%0d beats=%0d", tag, count_field, mode, beats);
    end
  endtask

  initial begin
    int c, n, stale;

    vecs[0] = '{5,   0, 5,   0};
    vecs[1] = '{0,   0, 0,   0};
    vecs[2] = '{5,   2, 5,   0};
    vecs[3] = '{250, 0, 219, 1};
    vecs[4] = '{8,   1, 8,   0};
    vecs[5] = '{255, 3, 219, 1};
    vecs[6] = '{219, 1, 219, 0};
    vecs[7] = '{1,   3, 1,   0};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_stream($sformatf("vec%0d", i), vecs[i].count_field, vecs[i].mode,
                 vecs[i].exp_beats, vecs[i].exp_clamp, 0);
    end

    for (int i = 0; i < 8; i++) begin
      c = ($urandom_range(0, 9) == 0) ? $urandom_range(220, 255) : $urandom_range(0, 40);
      n = (c > MAXC) ? MAXC : c;
      run_stream($sformatf("rnd%0d", i), c, 3, n, (c > MAXC) ? 1 : 0, 0);
    end

    // Reset while beat 3 of 8 is on the output, then a fresh short stream.
    run_stream("rst_mid", 8, 0, 8, 0, 2);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("mid_reset");
    rst   = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("stale_after_reset", stale == 0, stale, 0);
    run_stream("after_reset", 2, 0, 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
